// File: rtl/alu_exec.sv
// EX-stage ALU: logic/arith/slt/nor in one cycle, shifts iterate one bit per cycle.
// Latency is 1 cycle, or shamt+1 cycles for shifts; start is ignored while busy.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shtype_e;

    state_e           state_q, state_d;
    shtype_e          shtype_q, shtype_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             is_shift;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        op_res   = '0;
        is_shift = 1'b0;
        case (aluctl)
            4'd0:  op_res = a & b;
            4'd1:  op_res = a | b;
            4'd2:  op_res = a + b;
            4'd6:  op_res = a - b;
            4'd7:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd12: op_res = ~(a | b);
            4'd3, 4'd4, 4'd5: begin
                is_shift = 1'b1;
                op_res   = b;     // only reaches result when shamt is zero
            end
            default: op_res = '0;
        endcase
    end

    always_comb begin
        shifted = shreg_q;
        case (shtype_q)
            SH_LL:   shifted = {shreg_q[WIDTH-2:0], 1'b0};
            SH_RL:   shifted = {1'b0, shreg_q[WIDTH-1:1]};
            SH_RA:   shifted = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shifted = shreg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shtype_d = shtype_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        shreg_d = b;
                        cnt_d   = shamt;
                        state_d = S_SHIFT;
                        case (aluctl)
                            4'd3:    shtype_d = SH_LL;
                            4'd4:    shtype_d = SH_RL;
                            default: shtype_d = SH_RA;
                        endcase
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shtype_q <= SH_LL;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shtype_q <= shtype_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed bench for alu_exec against a behavioural operation model.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  aluctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks;
    int failures;

    alu_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluctl(aluctl),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [3:0] c, input logic [31:0] x,
                                              input logic [31:0] y, input logic [4:0] s);
        case (c)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd6:  return x - y;
            4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd12: return ~(x | y);
            4'd3:  return y << s;
            4'd4:  return y >> s;
            4'd5:  return $signed(y) >>> s;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [4:0] s);
        if ((c == 4'd3 || c == 4'd4 || c == 4'd5) && s != 5'd0) return int'(s) + 1;
        return 1;
    endfunction

    // Issues one op at a negedge, then watches cycles 1..lat+2 for busy/done timing.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] s);
        logic [31:0] exp;
        logic [31:0] got;
        int lat, first, ndone;
        exp = ref_model(c, x, y, s);
        lat = ref_lat(c, s);
        first = 0; ndone = 0; got = 32'hx;
        @(negedge clk);
        start = 1'b1; aluctl = c; a = x; b = y; shamt = s;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            checks++;
            if (busy !== (k < lat)) begin
                failures++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, (k < lat));
            end
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = k;
                    got = result;
                    checks++;
                    if (zero !== (exp == 32'd0)) begin
                        failures++;
                        $display("FAIL %s zero: got %b expected %b", name, zero, (exp == 32'd0));
                    end
                end
            end
        end
        checks++;
        if (first != lat || ndone != 1) begin
            failures++;
            $display("FAIL %s done timing: first at cycle %0d count %0d, expected cycle %0d count 1",
                     name, first, ndone, lat);
        end
        checks++;
        if (got !== exp || result !== exp) begin
            failures++;
            $display("FAIL %s result: got %h (held %h) expected %h", name, got, result, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; aluctl = '0; a = '0; b = '0; shamt = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset: result=%h zero=%b busy=%b done=%b expected 0/1/0/0",
                     result, zero, busy, done);
        end
    endtask

    task automatic test_add();
        run_op("add_5_7", 4'd2, 32'd5, 32'd7, 5'd0);
        checks++;
        if (result !== 32'd12 || done !== 1'b0) begin
            failures++;
            $display("FAIL add_hold: result=%h done=%b expected 0000000c/0", result, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cs [3];
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [31:0] es [3];
        cs = '{4'd6, 4'd7, 4'd12};
        xs = '{32'd3, 32'hFFFF_FFFF, 32'd0};
        ys = '{32'd3, 32'd1, 32'd0};
        es = '{32'd0, 32'd1, 32'hFFFF_FFFF};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                start = 1'b1; aluctl = cs[i]; a = xs[i]; b = ys[i]; shamt = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (done !== 1'b1 || result !== es[i] || zero !== (es[i] == 32'd0)) begin
                    failures++;
                    $display("FAIL b2b op%0d: done=%b result=%h zero=%b expected 1/%h/%b",
                             i, done, result, zero, es[i], (es[i] == 32'd0));
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b trailing done: got %b expected 0", done);
                end
            end
        end
    endtask

    task automatic test_sra_ignored_start();
        int ndone, first;
        logic [31:0] got;
        ndone = 0; first = 0; got = '0;
        @(negedge clk);
        start = 1'b1; aluctl = 4'd5; a = '0; b = 32'h8000_0000; shamt = 5'd4;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin aluctl = 4'd2; a = 32'd1; b = 32'd1; shamt = 5'd0; end
            if (k <= 4) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL sra busy cycle %0d: got %b expected 1", k, busy);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin first = k; got = result; end
            end
        end
        start = 1'b0;
        checks++;
        if (first != 5 || ndone != 1 || got !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra_ignored: first=%0d count=%0d result=%h expected 5/1/f8000000",
                     first, ndone, got);
        end
    endtask

    task automatic test_shift_extremes();
        run_op("sll_31", 4'd3, 32'd0, 32'd1, 5'd31);
        run_op("srl_31", 4'd4, 32'd0, 32'h8000_0000, 5'd31);
        run_op("sll_0", 4'd3, 32'd0, 32'h1234, 5'd0);
        run_op("undef_9", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    endtask

    task automatic test_reset_mid_shift();
        int ndone;
        ndone = 0;
        run_op("pre_reset_or", 4'd1, 32'h0000_00F0, 32'h0000_0F00, 5'd0);
        @(negedge clk);
        start = 1'b1; aluctl = 4'd4; a = '0; b = 32'h0000_FF00; shamt = 5'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: busy=%b result=%h zero=%b done=%b expected 0/0/1/0",
                     busy, result, zero, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: done pulses=%0d busy=%b expected 0/0", ndone, busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] codes [11];
        logic [3:0]  c;
        logic [31:0] x, y;
        logic [4:0]  s;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd4, 4'd5, 4'd10, 4'd15};
        for (int i = 0; i < 40; i++) begin
            c = codes[$urandom_range(0, 10)];
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? x : $urandom;
            s = 5'($urandom_range(0, 31));
            run_op("random", c, x, y, s);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fork
            begin
                test_reset();
                test_add();
                test_back_to_back();
                test_sra_ignored_start();
                test_shift_extremes();
                test_reset_mid_shift();
                test_random();
            end
            begin
                #500000;
                failures++;
                $display("FAIL watchdog: bench did not complete in time");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "watchdog");
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
